// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester ports and the SRAM-side strobes shared by sram_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface sram_arbiter_if;
  logic         bus_req;
  logic         bus_we;
  logic [15:0]  bus_addr;
  logic [127:0] bus_wdata;
  logic         core_req;
  logic         core_we;
  logic [15:0]  core_addr;
  logic [127:0] core_wdata;
  logic         bus_gnt;
  logic         core_gnt;
  logic         bus_rvalid;
  logic         core_rvalid;
  logic [127:0] rdata;
  logic         read;
  logic         write;
  logic [15:0]  addr;
  logic [127:0] write_data;
  logic [127:0] read_data;

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    input  core_req, core_we, core_addr, core_wdata,
    input  read_data,
    output bus_gnt, core_gnt, bus_rvalid, core_rvalid, rdata,
    output read, write, addr, write_data
  );

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    output core_req, core_we, core_addr, core_wdata,
    output read_data,
    input  bus_gnt, core_gnt, bus_rvalid, core_rvalid, rdata,
    input  read, write, addr, write_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM between the AHB bus and the AES core.
// Define SRAM_ARB_LOCK_EN to add core_lock, which lets the core keep ownership after its grant.
module sram_arbiter (
  input  logic clk,
  input  logic rst,
`ifdef SRAM_ARB_LOCK_EN
  input  logic core_lock,
`endif
  sram_arbiter_if.slave sif
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t       r_state;
  logic         r_last_core;  // also identifies the reader during RDATA
  logic         r_read;
  logic         r_write;
  logic         r_bus_gnt;
  logic         r_core_gnt;
  logic         r_bus_rvalid;
  logic         r_core_rvalid;
  logic [15:0]  r_addr;
  logic [127:0] r_wdata;
  logic [127:0] r_rdata;

  logic w_lock_hold;
  logic w_bus_ok;
  logic w_pick_core;
  logic w_any;

`ifdef SRAM_ARB_LOCK_EN
  assign w_lock_hold = core_lock & r_last_core;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_bus_ok    = sif.bus_req & ~w_lock_hold;
  // Core wins when it is the only eligible requester, or on a tie when the bus was served last.
  assign w_pick_core = sif.core_req & (~w_bus_ok | ~r_last_core);
  assign w_any       = w_bus_ok | sif.core_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_core   <= 1'b1;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_bus_gnt     <= 1'b0;
      r_core_gnt    <= 1'b0;
      r_bus_rvalid  <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ACCESS;
            r_last_core <= w_pick_core;
            r_bus_gnt   <= ~w_pick_core;
            r_core_gnt  <= w_pick_core;
            r_write     <= w_pick_core ? sif.core_we : sif.bus_we;
            r_read      <= w_pick_core ? ~sif.core_we : ~sif.bus_we;
            r_addr      <= w_pick_core ? sif.core_addr : sif.bus_addr;
            r_wdata     <= w_pick_core ? sif.core_wdata : sif.bus_wdata;
          end
        end
        ACCESS: begin
          r_bus_gnt  <= 1'b0;
          r_core_gnt <= 1'b0;
          r_read     <= 1'b0;
          r_write    <= 1'b0;
          if (r_read) begin
            r_rdata       <= sif.read_data;
            r_bus_rvalid  <= ~r_last_core;
            r_core_rvalid <= r_last_core;
            r_state       <= RDATA;
          end else begin
            r_state <= IDLE;
          end
        end
        RDATA: begin
          r_bus_rvalid  <= 1'b0;
          r_core_rvalid <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sif.bus_gnt     = r_bus_gnt;
  assign sif.core_gnt    = r_core_gnt;
  assign sif.bus_rvalid  = r_bus_rvalid;
  assign sif.core_rvalid = r_core_rvalid;
  assign sif.rdata       = r_rdata;
  assign sif.read        = r_read;
  assign sif.write       = r_write;
  assign sif.addr        = r_addr;
  assign sif.write_data  = r_wdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Compile with SRAM_ARB_LOCK_EN to also exercise core_lock.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic core_lock;

  sram_arbiter_if sif ();

  sram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SRAM_ARB_LOCK_EN
    .core_lock (core_lock),
`endif
    .sif       (sif)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K_KEY  = 128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516;
  localparam logic [127:0] K_DATA = 128'hAAF43DDD_A22100EF_8766450A_B4321176;

  // SRAM behaviour: combinational read during the strobe, write on the clock edge.
  bit [127:0] sram_mem [0:255];
  assign sif.read_data = sif.read ? 128'(sram_mem[sif.addr[7:0]]) : 128'd0;
  always @(posedge clk) if (sif.write) sram_mem[sif.addr[7:0]] <= sif.write_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  bit grant_hist[$];  // 0 = bus, 1 = core, as observed

  // Reference model state: what each requester should see, tracked per transaction.
  bit [127:0]   ref_mem [0:255];
  int           m_busy;      // edges still owned by the transaction in flight
  int           m_rv_cnt;    // edges until the read result is presented
  bit           m_rv_core;
  logic [127:0] m_rv_data;
  bit           m_last_core;
  logic e_bus_gnt, e_core_gnt, e_bus_rv, e_core_rv, e_read, e_write;
  logic [15:0]  e_addr;
  logic [127:0] e_wdata, e_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rv_cnt = 0; m_last_core = 1'b1;
    e_bus_gnt = 0; e_core_gnt = 0; e_bus_rv = 0; e_core_rv = 0;
    e_read = 0; e_write = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  // Predicts the outputs for the cycle after the coming rising edge, given current inputs.
  task automatic model_step();
    bit lock_now, bus_in, core_in, win_core, we;
    logic [15:0] a;
    e_bus_gnt = 0; e_core_gnt = 0; e_bus_rv = 0; e_core_rv = 0; e_read = 0; e_write = 0;
`ifdef SRAM_ARB_LOCK_EN
    lock_now = core_lock;
`else
    lock_now = 1'b0;
`endif
    if (m_rv_cnt > 0) begin
      m_rv_cnt--;
      if (m_rv_cnt == 0) begin
        if (m_rv_core) e_core_rv = 1; else e_bus_rv = 1;
        e_rdata = m_rv_data;
      end
    end
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      bus_in  = sif.bus_req && !(lock_now && m_last_core);
      core_in = sif.core_req;
      if (bus_in || core_in) begin
        if (bus_in && core_in) win_core = !m_last_core;  // alternate on a tie
        else                   win_core = core_in;
        we      = win_core ? sif.core_we : sif.bus_we;
        a       = win_core ? sif.core_addr : sif.bus_addr;
        e_addr  = a;
        e_wdata = win_core ? sif.core_wdata : sif.bus_wdata;
        e_write = we;
        e_read  = !we;
        if (win_core) e_core_gnt = 1; else e_bus_gnt = 1;
        m_last_core = win_core;
        if (we) begin
          ref_mem[a[7:0]] = e_wdata;
          m_busy = 1;
        end else begin
          m_busy    = 2;
          m_rv_cnt  = 1;
          m_rv_core = win_core;
          m_rv_data = ref_mem[a[7:0]];
        end
        n_txn++;
        $display("txn %0d t=%0t %s %s addr=%0d", n_txn, $time,
                 win_core ? "core" : "bus", we ? "write" : "read", a);
      end
    end
  endtask

  task automatic check_outputs();
    check("bus_gnt",     sif.bus_gnt,     e_bus_gnt);
    check("core_gnt",    sif.core_gnt,    e_core_gnt);
    check("bus_rvalid",  sif.bus_rvalid,  e_bus_rv);
    check("core_rvalid", sif.core_rvalid, e_core_rv);
    check("read",        sif.read,        e_read);
    check("write",       sif.write,       e_write);
    check("addr",        sif.addr,        e_addr);
    check("write_data",  sif.write_data,  e_wdata);
    check("rdata",       sif.rdata,       e_rdata);
    check("strobe_excl", sif.read & sif.write, 1'b0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_cycle();
    model_step();
    @(posedge clk); #1;
    check_outputs();
    if (sif.bus_gnt)  grant_hist.push_back(1'b0);
    if (sif.core_gnt) grant_hist.push_back(1'b1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raises one request, waits (bounded) for its grant, then drops it; returns inside ACCESS.
  task automatic do_txn(input bit core, input bit we, input logic [15:0] a, input logic [127:0] d);
    bit got = 0;
    if (core) begin
      sif.core_req = 1; sif.core_we = we; sif.core_addr = a; sif.core_wdata = d;
    end else begin
      sif.bus_req = 1; sif.bus_we = we; sif.bus_addr = a; sif.bus_wdata = d;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      run_cycle();
      got = core ? sif.core_gnt : sif.bus_gnt;
    end
    if (core) sif.core_req = 0; else sif.bus_req = 0;
    check("txn_granted", got, 1'b1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_random();
    if (sif.bus_req && sif.bus_gnt) begin
      sif.bus_req = 1'($urandom_range(0, 1));
      sif.bus_we = 1'($urandom_range(0, 1)); sif.bus_addr = 16'($urandom_range(0, 3) * 16);
      sif.bus_wdata = rand128();
    end else if (sif.bus_req) begin
      if ($urandom_range(0, 15) == 0) sif.bus_req = 0;
    end else if ($urandom_range(0, 1) == 1) begin
      sif.bus_req = 1;
      sif.bus_we = 1'($urandom_range(0, 1)); sif.bus_addr = 16'($urandom_range(0, 3) * 16);
      sif.bus_wdata = rand128();
    end
    if (sif.core_req && sif.core_gnt) begin
      sif.core_req = 1'($urandom_range(0, 1));
      sif.core_we = 1'($urandom_range(0, 1)); sif.core_addr = 16'($urandom_range(0, 3) * 16);
      sif.core_wdata = rand128();
    end else if (sif.core_req) begin
      if ($urandom_range(0, 15) == 0) sif.core_req = 0;
    end else if ($urandom_range(0, 1) == 1) begin
      sif.core_req = 1;
      sif.core_we = 1'($urandom_range(0, 1)); sif.core_addr = 16'($urandom_range(0, 3) * 16);
      sif.core_wdata = rand128();
    end
`ifdef SRAM_ARB_LOCK_EN
    if ($urandom_range(0, 31) == 0) core_lock = !core_lock;
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; core_lock = 1'b0;
    sif.bus_req = 0; sif.bus_we = 0; sif.bus_addr = '0; sif.bus_wdata = '0;
    sif.core_req = 0; sif.core_we = 0; sif.core_addr = '0; sif.core_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Key write from the bus.
    do_txn(0, 1, 16'd0, K_KEY);
    check("w_key_write", sif.write, 1'b1);
    check("w_key_addr", sif.addr, 16'd0);
    check("w_key_wdata", sif.write_data, K_KEY);
    check("w_key_gnt", sif.bus_gnt, 1'b1);
    run_cycle();
    check("w_key_idle", sif.write | sif.bus_gnt, 1'b0);

    // Data write then read back at address 32.
    do_txn(0, 1, 16'd32, K_DATA);
    idle(1);
    do_txn(0, 0, 16'd32, '0);
    check("rd_strobe", sif.read, 1'b1);
    check("rd_addr", sif.addr, 16'd32);
    run_cycle();
    check("rd_rvalid", sif.bus_rvalid, 1'b1);
    check("rd_rdata", sif.rdata, K_DATA);
    idle(2);
    check("rd_hold", sif.rdata, K_DATA);

    // Both requesting from reset: bus first, then alternate.
    do_reset();
    sif.bus_req = 1; sif.bus_we = 1; sif.bus_addr = 16'd0; sif.bus_wdata = rand128();
    sif.core_req = 1; sif.core_we = 1; sif.core_addr = 16'd16; sif.core_wdata = rand128();
    grant_hist.delete();
    idle(10);
    check("rr_count", 32'(grant_hist.size()), 32'd5);
    if (grant_hist.size() >= 4) begin
      check("rr_first", grant_hist[0], 1'b0);
      check("rr_second", grant_hist[1], 1'b1);
      check("rr_third", grant_hist[2], 1'b0);
      check("rr_fourth", grant_hist[3], 1'b1);
    end
    sif.bus_req = 0; sif.core_req = 0;
    idle(3);

    // Reset during a core read; a pending bus read must then be served normally.
    do_txn(1, 0, 16'd16, '0);
    check("rst_pre_read", sif.read, 1'b1);
    sif.bus_req = 1; sif.bus_we = 0; sif.bus_addr = 16'd32;
    #2;
    do_reset();
    check("rst_read_low", sif.read, 1'b0);
    do_txn(0, 0, 16'd32, '0);
    run_cycle();
    check("rst_bus_rvalid", sif.bus_rvalid, 1'b1);
    check("rst_no_core_rv", sif.core_rvalid, 1'b0);
    check("rst_rdata", sif.rdata, K_DATA);
    idle(2);

`ifdef SRAM_ARB_LOCK_EN
    // Locked core keeps winning; releasing the lock hands the next grant to the bus.
    do_reset();
    core_lock = 1'b1;
    sif.bus_req = 1; sif.bus_we = 1; sif.bus_addr = 16'd48; sif.bus_wdata = rand128();
    sif.core_req = 1; sif.core_we = 1; sif.core_addr = 16'd16; sif.core_wdata = rand128();
    grant_hist.delete();
    idle(10);
    check("lock_count", 32'(grant_hist.size()), 32'd5);
    for (int i = 0; i < grant_hist.size(); i++) check("lock_core_only", grant_hist[i], 1'b1);
    core_lock = 1'b0;
    grant_hist.delete();
    idle(4);
    check("unlock_any", 32'(grant_hist.size() > 0), 32'd1);
    if (grant_hist.size() > 0) check("unlock_bus", grant_hist[0], 1'b0);
    sif.bus_req = 0; sif.core_req = 0;
    idle(3);
`endif

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      drive_random();
      run_cycle();
    end
    sif.bus_req = 0; sif.core_req = 0; core_lock = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 bus_req  in  1  AHB-side access request, held until bus_gnt.
REQ-005 bus_we  in  1  AHB-side write (1) / read (0).
REQ-006 bus_addr  in  16  AHB-side SRAM address (key at 0, data at 32).
REQ-007 bus_wdata  in  128  AHB-side write data.
REQ-008 core_req / core_we / core_addr / core_wdata  in  1/1/16/128  AES-core-side equivalents of REQ-004..007.
REQ-009 bus_gnt, core_gnt  out  1 each  one-cycle grant pulse, asserted in the command cycle.
REQ-010 bus_rvalid, core_rvalid  out  1 each  one-cycle read-data-valid pulse for the granted reader.
REQ-011 rdata  out  128  registered read data, shared by both requesters.
REQ-012 read, write  out  1 each  SRAM strobes, registered.
REQ-013 addr  out  16  SRAM address, registered.
REQ-014 write_data  out  128  SRAM write data, registered.
REQ-015 read_data  in  128  SRAM read data, valid combinationally during the read-strobe cycle.
REQ-016 core_lock  in  1  core holds SRAM ownership (present only with SRAM_ARB_LOCK_EN).

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, RDATA.
REQ-018 In IDLE with any request pending, the FSM SHALL select a winner, register addr/write_data/read/write from that requester, and move to ACCESS.
REQ-019 In ACCESS, exactly one of read/write SHALL be high and the winner's gnt SHALL be high for exactly that cycle.
REQ-020 On a write, ACCESS SHALL return to IDLE, giving 2 cycles per write.
REQ-021 On a read, ACCESS SHALL capture read_data into rdata and move to RDATA.
REQ-022 In RDATA, the reader's rvalid SHALL be high for one cycle and the FSM SHALL return to IDLE, giving 3 cycles per read.
REQ-023 rdata SHALL hold its value until the next read completes.
REQ-024 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins.
REQ-025 last_gnt SHALL reset to "core", so the bus wins the first tie.
REQ-026 A lone requester SHALL win regardless of last_gnt.
REQ-027 Requests SHALL be sampled only in IDLE.
REQ-028 A request deasserted before grant SHALL be dropped without any SRAM strobe.
REQ-029 A request still high after its grant SHALL be treated as a new request.
REQ-030 read and write SHALL never be high in the same cycle.
REQ-031 addr and write_data SHALL be held stable throughout ACCESS.

Reset
REQ-032 While rst is high: state=IDLE, read=write=0, addr=0, write_data=0, rdata=0, all gnt/rvalid=0, last_gnt=core.
REQ-033 Assertion of rst mid-ACCESS or mid-RDATA SHALL abandon the access immediately, with no further strobe or rvalid.

Configuration
REQ-034 With SRAM_ARB_LOCK_EN defined, the core_lock port SHALL exist.
REQ-035 With SRAM_ARB_LOCK_EN defined, while core_lock=1 and last_gnt=core, bus requests SHALL wait and core requests SHALL win even against round-robin.
REQ-036 With SRAM_ARB_LOCK_EN defined, releasing core_lock SHALL restore round-robin from the next IDLE.
REQ-037 Without SRAM_ARB_LOCK_EN, core_lock SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-038 Reset then bus write addr=0, wdata=128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516 -> one cycle later write=1, addr=0, write_data equals wdata, bus_gnt=1; IDLE next cycle.
REQ-039 Bus read addr=32 after SRAM addr 32 is written with 128'hAAF43DDD_A22100EF_8766450A_B4321176 -> read=1/addr=32 in ACCESS; next cycle bus_rvalid=1, rdata equals that value.
REQ-040 bus_req and core_req both high from reset -> bus granted first, core second, then alternating while both are held.
REQ-041 rst asserted during ACCESS of a core read -> read=0 immediately, no core_rvalid; after release, a pending bus_req is granted normally.
REQ-042 SRAM_ARB_LOCK_EN with core_lock=1 and both requesting continuously after a core grant -> four consecutive core grants, no bus_gnt; core_lock=0 -> next grant goes to bus.
